// File: rtl/dvp_frame_gen.sv
// DVP camera-source generator: derives PCLK from sys_clk and emits VSYNC/HSYNC/HREF
// framing with a selectable test pattern, frame after frame while enabled.
module dvp_frame_gen #(
  parameter int DVP_DATA_W = 8,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int BPP        = 2,
  parameter int H_TOTAL    = 784,
  parameter int HS_W       = 80,
  parameter int HBP        = 40,
  parameter int VS_LINES   = 3,
  parameter int VBP_LINES  = 17,
  parameter int VFP_LINES  = 10,
  parameter int PCLK_DIV   = 6
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  gen_en_i,
  input  logic [1:0]            pattern_sel_i,
  output logic                  dvp_pclk_o,
  output logic                  dvp_vsync_o,
  output logic                  dvp_hsync_o,
  output logic                  dvp_href_o,
  output logic [DVP_DATA_W-1:0] dvp_d_o,
  output logic                  frame_done_o,
  output logic                  busy_o,
  output logic [15:0]           frame_cnt_o
);

  localparam int L   = H_TOTAL * BPP;
  localparam int H_W = $clog2(L + 1);
  localparam int D_W = $clog2(PCLK_DIV + 1);
  localparam int S_W = $clog2(BPP + 1);
  localparam int V_W = 16;

  localparam logic [H_W-1:0] H_LAST    = H_W'(L - 1);
  localparam logic [H_W-1:0] HS_END    = H_W'(HS_W * BPP);
  localparam logic [H_W-1:0] HREF_BEG  = H_W'((HS_W + HBP) * BPP);
  localparam logic [H_W-1:0] HREF_END  = H_W'((HS_W + HBP + H_ACTIVE) * BPP);
  localparam logic [S_W-1:0] SUB_LAST  = S_W'(BPP - 1);
  localparam logic [D_W-1:0] DIV_LAST  = D_W'(PCLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP} state_t;

  function automatic int lines_of(state_t s);
    case (s)
      S_VSYNC:  return VS_LINES;
      S_VBP:    return VBP_LINES;
      S_ACTIVE: return V_ACTIVE;
      S_VFP:    return VFP_LINES;
      default:  return 0;
    endcase
  endfunction

  // Successor of a state with empty (0-line) phases skipped; S_IDLE means the frame is over.
  function automatic state_t next_phase(state_t s);
    state_t n;
    n = S_IDLE;
    case (s)
      S_IDLE:   n = (VS_LINES > 0)  ? S_VSYNC  : (VBP_LINES > 0) ? S_VBP :
                    (V_ACTIVE > 0)  ? S_ACTIVE : (VFP_LINES > 0) ? S_VFP : S_IDLE;
      S_VSYNC:  n = (VBP_LINES > 0) ? S_VBP    : (V_ACTIVE > 0)  ? S_ACTIVE :
                    (VFP_LINES > 0) ? S_VFP    : S_IDLE;
      S_VBP:    n = (V_ACTIVE > 0)  ? S_ACTIVE : (VFP_LINES > 0) ? S_VFP : S_IDLE;
      S_ACTIVE: n = (VFP_LINES > 0) ? S_VFP    : S_IDLE;
      default:  n = S_IDLE;
    endcase
    return n;
  endfunction

  logic [D_W-1:0]  r_div;
  logic            r_pclk;
  state_t          r_state;
  logic [H_W-1:0]  r_h;
  logic [V_W-1:0]  r_v;
  logic            r_vsync, r_hsync, r_href, r_frame_done, r_busy;
  logic [DVP_DATA_W-1:0] r_d;
  logic [15:0]     r_frame_cnt;
  logic [1:0]      r_pat;
  logic [4:0]      r_b;     // only b mod 32 is ever observed, so a 5-bit wrap suffices
  logic [7:0]      r_col;   // only col[7:0] is ever observed
  logic [S_W-1:0]  r_sub;

  logic            w_div_wrap, w_tick;
  state_t          w_state_nxt;
  logic [H_W-1:0]  w_h_nxt;
  logic [V_W-1:0]  w_v_nxt;
  logic            w_frame_start, w_frame_end;
  logic            w_vsync_nxt, w_hsync_nxt, w_href_nxt;
  logic [1:0]      w_pat;
  logic [4:0]      w_b_base;
  logic [7:0]      w_col_base, w_col_adv, w_row, w_pix8;
  logic [S_W-1:0]  w_sub_base, w_sub_adv;
  logic [DVP_DATA_W-1:0] w_d_nxt;

  assign w_div_wrap = (r_div == DIV_LAST);
  assign w_tick     = w_div_wrap & r_pclk;

  // NOTE: asynchronous active-low reset with non-blocking assignments for all state.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_pclk <= 1'b0;
    end else if (w_div_wrap) begin
      r_div  <= '0;
      r_pclk <= ~r_pclk;
    end else begin
      r_div  <= r_div + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)      r_state <= S_IDLE;
    else if (w_tick) r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_h_nxt       = r_h;
    w_v_nxt       = r_v;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    if (r_state == S_IDLE) begin
      if (gen_en_i && next_phase(S_IDLE) != S_IDLE) begin
        w_state_nxt   = next_phase(S_IDLE);
        w_h_nxt       = '0;
        w_v_nxt       = '0;
        w_frame_start = 1'b1;
      end
    end else if (r_h != H_LAST) begin
      w_h_nxt = r_h + 1'b1;
    end else begin
      w_h_nxt = '0;
      if (r_v != V_W'(lines_of(r_state) - 1)) begin
        w_v_nxt = r_v + 1'b1;
      end else begin
        w_v_nxt     = '0;
        w_state_nxt = next_phase(r_state);
        if (w_state_nxt == S_IDLE) begin
          w_frame_end = 1'b1;
          if (gen_en_i) begin
            w_state_nxt   = next_phase(S_IDLE);
            w_frame_start = 1'b1;
          end
        end
      end
    end
  end

  // Outputs are computed for the slot being entered and registered on the tick.
  always_comb begin
    w_vsync_nxt = (w_state_nxt == S_VSYNC);
    w_hsync_nxt = !((w_state_nxt != S_IDLE) && (w_h_nxt < HS_END));
    w_href_nxt  = (w_state_nxt == S_ACTIVE) && (w_h_nxt >= HREF_BEG) && (w_h_nxt < HREF_END);
    w_pat       = w_frame_start ? pattern_sel_i : r_pat;
    w_b_base    = w_frame_start ? 5'd0 : r_b;
    w_col_base  = (w_h_nxt == '0) ? 8'd0 : r_col;
    w_sub_base  = (w_h_nxt == '0) ? '0 : r_sub;
    w_row       = w_v_nxt[7:0];
    if (w_sub_base == SUB_LAST) begin
      w_sub_adv = '0;
      w_col_adv = w_col_base + 1'b1;
    end else begin
      w_sub_adv = w_sub_base + 1'b1;
      w_col_adv = w_col_base;
    end
    case (w_pat)
      2'd0:    w_pix8 = {3'b000, w_b_base};
      2'd1:    w_pix8 = w_col_base;
      2'd2:    w_pix8 = w_row;
      default: w_pix8 = (w_col_base[3] ^ w_row[3]) ? 8'hFF : 8'h00;
    endcase
    w_d_nxt = '0;
    if (w_href_nxt) begin
      for (int i = 0; i < DVP_DATA_W && i < 8; i++) w_d_nxt[i] = w_pix8[i];
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h          <= '0;
      r_v          <= '0;
      r_vsync      <= 1'b0;
      r_hsync      <= 1'b1;
      r_href       <= 1'b0;
      r_d          <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_cnt  <= '0;
      r_pat        <= 2'd0;
      r_b          <= '0;
      r_col        <= '0;
      r_sub        <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_tick) begin
        r_h          <= w_h_nxt;
        r_v          <= w_v_nxt;
        r_vsync      <= w_vsync_nxt;
        r_hsync      <= w_hsync_nxt;
        r_href       <= w_href_nxt;
        r_d          <= w_d_nxt;
        r_busy       <= (w_state_nxt != S_IDLE);
        r_pat        <= w_pat;
        r_frame_done <= w_frame_end;
        r_b          <= w_href_nxt ? (w_b_base + 1'b1) : w_b_base;
        r_col        <= w_href_nxt ? w_col_adv : w_col_base;
        r_sub        <= w_href_nxt ? w_sub_adv : w_sub_base;
        if (w_frame_end) r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign dvp_pclk_o   = r_pclk;
  assign dvp_vsync_o  = r_vsync;
  assign dvp_hsync_o  = r_hsync;
  assign dvp_href_o   = r_href;
  assign dvp_d_o      = r_d;
  assign frame_done_o = r_frame_done;
  assign busy_o       = r_busy;
  assign frame_cnt_o  = r_frame_cnt;

endmodule
